// File: rtl/ldst_core.sv
// ============================================================================
// ldst_core : multi-cycle load/store core (LW, SW, ADDI, HALT) | rev 1.0
// ============================================================================
`default_nettype none

module ldst_core #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int DMEM_WORDS = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_data,
  output logic [XLEN-1:0] pc,
  output logic [2:0]      state,
  output logic            wb_valid,
  output logic [4:0]      wb_reg,
  output logic [XLEN-1:0] wb_data,
  output logic            halted,
  output logic            err,
  output logic [15:0]     retired
);

  localparam int RIDX = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int AW   = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_ADDR   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t          cur;
  logic [31:0]     ir;
  logic [XLEN-1:0] a, b, aluout, mdr;
  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] dmem [DMEM_WORDS];

  logic [5:0]      opcode;
  logic [4:0]      rs_f, rt_f;
  logic [XLEN-1:0] imm_ext, addr_sum, widx, mem_word, wb_val;
  logic            rs_bad, rt_bad, legal_op, mem_fault;

  assign state    = cur;
  assign opcode   = ir[31:26];
  assign rs_f     = ir[25:21];
  assign rt_f     = ir[20:16];
  assign imm_ext  = XLEN'($signed(ir[15:0]));
  assign addr_sum = a + imm_ext;
  // Any index bit at or above log2(NREG) means the register does not exist.
  assign rs_bad   = (rs_f >> RIDX) != 5'd0;
  assign rt_bad   = (rt_f >> RIDX) != 5'd0;
  assign legal_op = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_ADDI);
  assign widx     = aluout >> 2;
  assign mem_fault = (aluout[1:0] != 2'b00) || (widx >= XLEN'(DMEM_WORDS));
  assign mem_word = dmem[widx[AW-1:0]];
  assign wb_val   = (opcode == OP_LW) ? mdr : aluout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur      <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      aluout   <= '0;
      mdr      <= '0;
      wb_valid <= 1'b0;
      wb_reg   <= '0;
      wb_data  <= '0;
      halted   <= 1'b0;
      err      <= 1'b0;
      retired  <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
    end else begin
      case (cur)
        S_FETCH: begin
          ir  <= instr_data;
          pc  <= pc + XLEN'(4);
          cur <= S_DECODE;
        end
        S_DECODE: begin
          a <= (rs_f == 5'd0) ? '0 : regs[rs_f[RIDX-1:0]];
          b <= (rt_f == 5'd0) ? '0 : regs[rt_f[RIDX-1:0]];
          if (opcode == OP_HALT) begin
            cur    <= S_HALT;
            halted <= 1'b1;
          end else if (!legal_op || rs_bad || rt_bad) begin
            cur    <= S_HALT;
            halted <= 1'b1;
            err    <= 1'b1;
          end else begin
            cur <= S_ADDR;
          end
        end
        S_ADDR: begin
          aluout <= addr_sum;
          if (opcode == OP_ADDI) begin
            // Writeback outputs are loaded on entry so they are valid during WB.
            wb_valid <= 1'b1;
            wb_reg   <= rt_f;
            wb_data  <= addr_sum;
            cur      <= S_WB;
          end else begin
            cur <= S_MEM;
          end
        end
        S_MEM: begin
          if (mem_fault) begin
            cur    <= S_HALT;
            halted <= 1'b1;
            err    <= 1'b1;
          end else if (opcode == OP_LW) begin
            mdr      <= mem_word;
            wb_valid <= 1'b1;
            wb_reg   <= rt_f;
            wb_data  <= mem_word;
            cur      <= S_WB;
          end else begin
            dmem[widx[AW-1:0]] <= b;
            retired <= retired + 16'd1;
            cur     <= S_FETCH;
          end
        end
        S_WB: begin
          if (rt_f != 5'd0) regs[rt_f[RIDX-1:0]] <= wb_val;
          wb_valid <= 1'b0;
          retired  <= retired + 16'd1;
          cur      <= S_FETCH;
        end
        S_HALT: cur <= S_HALT;
        default: cur <= S_FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/ldst_core.md
LDST_CORE -- requirements
Module: ldst_core

Interface
REQ-001 Parameter XLEN, default 32: datapath, register and data-memory word width; minimum 16.
REQ-002 Parameter NREG, default 32: register count; power of 2, 2..32.
REQ-003 Parameter DMEM_WORDS, default 64: data-memory depth in words.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset; asynchronous, active-low.
REQ-006 Port instr_data  input  32  instruction word at byte address pc, read combinationally.
REQ-007 Port pc  output  XLEN  current fetch byte address.
REQ-008 Port state  output  3  FSM state code: FETCH=0, DECODE=1, ADDR=2, MEM=3, WB=4, HALT=5.
REQ-009 Port wb_valid  output  1  one-cycle pulse while a register write commits.
REQ-010 Port wb_reg  output  5  destination index of the commit; wb_data  output  XLEN  value written.
REQ-011 Port halted  output  1  core in HALT; err  output  1  halt caused by a fault.
REQ-012 Port retired  output  16  retired-instruction count.

Function
REQ-013 Encoding: opcode [31:26], rs [25:21], rt [20:16], imm [15:0]; imm sign-extended to XLEN.
REQ-014 Supported opcodes: LW 0x23, SW 0x2B, ADDI 0x08, HALT 0x3F; any other opcode is illegal.
REQ-015 FETCH: latch instr_data into IR; pc <= pc+4, wrapping modulo 2^XLEN; next state DECODE.
REQ-016 DECODE: read rs and rt into A and B; HALT opcode -> HALT with err=0; illegal opcode, or rs/rt >= NREG -> HALT with err=1.
REQ-017 ADDR: ALUOut <= A + signext(imm), modulo 2^XLEN; ADDI -> WB; LW/SW -> MEM.
REQ-018 MEM fault: ALUOut[1:0] != 0 or word index ALUOut>>2 >= DMEM_WORDS -> HALT, err=1, no memory write, no register write.
REQ-019 MEM, LW: MDR <= dmem[ALUOut>>2]; next state WB.
REQ-020 MEM, SW: dmem[ALUOut>>2] <= B; retired increments; next state FETCH.
REQ-021 WB: reg[rt] <= MDR (LW) or ALUOut (ADDI); wb_valid=1, wb_reg=rt, wb_data=written value; retired increments; next state FETCH.
REQ-022 Register 0 reads zero; a write to rt=0 is discarded, but wb_valid still pulses with wb_data showing the discarded value.
REQ-023 Latency: LW 5 cycles; SW 4 cycles; ADDI 4 cycles; HALT opcode 2 cycles to reach HALT.
REQ-024 wb_valid is 0 in every state except WB; wb_reg and wb_data hold their last values outside WB.
REQ-025 Read-after-write: an instruction whose DECODE follows a WB to the same register reads the new value.
REQ-026 HALT is absorbing: pc, registers, memory and retired freeze; halted=1; only reset exits.
REQ-027 retired wraps from 0xFFFF to 0x0000; faulting and HALT instructions do not count.

Reset
REQ-028 rst low forces, asynchronously: state=FETCH, pc=0, IR/A/B/ALUOut/MDR=0, all registers=0, all dmem words=0, wb_valid=0, wb_reg=0, wb_data=0, halted=0, err=0, retired=0.
REQ-029 Reset asserted in any state, including mid-instruction or HALT, aborts the instruction with no partial register or memory write.
REQ-030 First fetch occurs on the first rising clk edge after rst deasserts.

Verification
REQ-031 ADDI r1,r0,0x10; SW r1,4(r0); LW r2,4(r0) -> wb pulses (1,0x10) then (2,0x10); retired=3 after 13 cycles; pc=12.
REQ-032 ADDI r3,r0,-4 -> wb_data=0xFFFFFFFC; then LW r4,8(r3) -> loads dmem[1], the word stored by REQ-031's sequence.
REQ-033 LW r1,2(r0) (misaligned) -> HALT, err=1, r1 unchanged, retired unchanged; LW r1,256(r0) with DMEM_WORDS=64 -> HALT, err=1.
REQ-034 Opcode 0x3F -> halted=1, err=0 two cycles after its fetch; further clocks leave pc and retired unchanged.
REQ-035 Assert rst during MEM of an SW to address 0 -> dmem[0] remains 0; state=FETCH and pc=0 immediately, without a clock edge.
REQ-036 Rerun REQ-031 with XLEN=16, NREG=8, DMEM_WORDS=16 -> same results; ADDI r9,... -> HALT, err=1.
